// File: rtl/btn_counter_reader.sv
// -----------------------------------------------------------------------------
// btn_counter_reader
//
// Reads two raw push-buttons, synchronizes each through a two-flop chain,
// debounces them on a shared divided sample tick and turns every accepted
// press into an up or down step of a modulo counter shown on the LEDs.
//
// Ports:
//   clk        in   system clock, all state rising-edge
//   rst        in   asynchronous active-low reset
//   btn_up     in   raw up button, active-high, asynchronous to clk
//   btn_down   in   raw down button, active-high, asynchronous to clk
//   leds       out  current count (registered), COUNTER_WIDTH bits
//   up_pulse   out  one-cycle registered pulse per accepted up press
//   down_pulse out  one-cycle registered pulse per accepted down press
// -----------------------------------------------------------------------------
module btn_counter_reader #(
  parameter int DEB_WIDTH     = 22,
  parameter int DEB_MAX       = 2_500_000,
  parameter int DEB_SAMPLES   = 3,
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 2**COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_up,
  input  logic                     btn_down,
  output logic [COUNTER_WIDTH-1:0] leds,
  output logic                     up_pulse,
  output logic                     down_pulse
);

  // Sample counter wide enough to hold DEB_SAMPLES.
  localparam int CNT_W = $clog2(DEB_SAMPLES + 1);

  localparam logic [DEB_WIDTH-1:0]     DIV_LAST = DEB_WIDTH'(DEB_MAX - 1);
  localparam logic [DEB_WIDTH-1:0]     DIV_ONE  = DEB_WIDTH'(1);
  localparam logic [CNT_W-1:0]         CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
  // Count value that, with the current agreeing sample, completes qualification.
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DEB_SAMPLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] VAL_ZERO = COUNTER_WIDTH'(0);
  localparam logic [COUNTER_WIDTH-1:0] VAL_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] VAL_TOP  = COUNTER_WIDTH'(COUNTER_MAX - 1);

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]               meta_q;
  logic [1:0]               sync_q;
  logic [DEB_WIDTH-1:0]     div_q;
  logic [DEB_WIDTH-1:0]     div_d;
  logic                     tick_s;
  logic [1:0]               state_q [2];
  logic [1:0]               state_d [2];
  logic [CNT_W-1:0]         cnt_q   [2];
  logic [CNT_W-1:0]         cnt_d   [2];
  logic [1:0]               fire_s;
  logic [1:0]               pulse_q;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {btn_down, btn_up};
      sync_q <= meta_q;
    end
  end

  // Shared sample-tick divider: tick in the cycle the divider sits at its last value.
  always_comb begin
    tick_s = (div_q == DIV_LAST);
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Per-button debounce next state; only tick cycles advance the FSMs.
  // A pulse is raised only on the RELEASED/PRESS_CHK -> PRESSED transition.
  always_comb begin
    fire_s = 2'b00;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      if (tick_s) begin
        case (state_q[b])
          ST_RELEASED: begin
            if (sync_q[b]) begin
              if (DEB_SAMPLES == 1) begin
                state_d[b] = ST_PRESSED;
                cnt_d[b]   = CNT_ZERO;
                fire_s[b]  = 1'b1;
              end else begin
                state_d[b] = ST_PRESS_CHK;
                cnt_d[b]   = CNT_ONE;
              end
            end else begin
              state_d[b] = ST_RELEASED;
            end
          end
          ST_PRESS_CHK: begin
            if (sync_q[b]) begin
              if (cnt_q[b] == CNT_LAST) begin
                state_d[b] = ST_PRESSED;
                cnt_d[b]   = CNT_ZERO;
                fire_s[b]  = 1'b1;
              end else begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
              end
            end else begin
              state_d[b] = ST_RELEASED;
              cnt_d[b]   = CNT_ZERO;
            end
          end
          ST_PRESSED: begin
            if (!sync_q[b]) begin
              if (DEB_SAMPLES == 1) begin
                state_d[b] = ST_RELEASED;
                cnt_d[b]   = CNT_ZERO;
              end else begin
                state_d[b] = ST_RELEASE_CHK;
                cnt_d[b]   = CNT_ONE;
              end
            end else begin
              state_d[b] = ST_PRESSED;
            end
          end
          ST_RELEASE_CHK: begin
            if (!sync_q[b]) begin
              if (cnt_q[b] == CNT_LAST) begin
                state_d[b] = ST_RELEASED;
                cnt_d[b]   = CNT_ZERO;
              end else begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
              end
            end else begin
              // Bounce back to pressed: no new pulse, the press was already counted.
              state_d[b] = ST_PRESSED;
              cnt_d[b]   = CNT_ZERO;
            end
          end
          default: begin
            state_d[b] = ST_RELEASED;
            cnt_d[b]   = CNT_ZERO;
          end
        endcase
      end else begin
        state_d[b] = state_q[b];
      end
    end
  end

  // Debounce FSM state, sample counters and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= ST_RELEASED;
        cnt_q[b]   <= CNT_ZERO;
      end
      pulse_q <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      pulse_q <= fire_s;
    end
  end

  // Modulo up/down count from the registered pulses; wrap is explicit so a
  // modulus below 2**COUNTER_WIDTH works.
  always_comb begin
    count_d = count_q;
    case (pulse_q)
      2'b01: begin
        if (count_q == VAL_TOP) begin
          count_d = VAL_ZERO;
        end else begin
          count_d = count_q + VAL_ONE;
        end
      end
      2'b10: begin
        if (count_q == VAL_ZERO) begin
          count_d = VAL_TOP;
        end else begin
          count_d = count_q - VAL_ONE;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= VAL_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign leds       = count_q;
  assign up_pulse   = pulse_q[0];
  assign down_pulse = pulse_q[1];

endmodule
